eth_mac_pe_rx_frame_packer: RTL and testbench

//  Parametrised rx protocol-engine front end: packs the MAC byte stream into DW-bit words through a

---
 rtl/eth_mac_pe_rx_frame_packer.sv | 205 ++++++++++++++++++++
 tb/tb_eth_mac_pe_rx_frame_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_pe_rx_frame_packer.sv
// Rx protocol-engine front end: packs MAC bytes into DW-bit words via a small pre-cache,
// filters on destination MAC, strips/truncates, and drains words into the rx data buffer.
module eth_mac_pe_rx_frame_packer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int LW    = 12
) (
    input  logic              pe_rx_clk,
    input  logic              pe_rx_rstn,
    input  logic              pe_rx_logic_clr,
    input  logic [7:0]        rx_frame_byte_data,
    input  logic              rx_frame_byte_data_we,
    input  logic              rx_frame_byte_data_done,
    input  logic              rxdb_fifo_ready,
    output logic              rxdb_pe2fifo_we,
    output logic [DW-1:0]     rxdb_pe2fifo_wdata,
    output logic [DW/8-1:0]   rxdb_pe2fifo_wbe,
    output logic              rxdb_pe2fifo_we_done,
    output logic              rx_handle_done,
    output logic              rx_frame_drop,
    output logic              rx_frame_truncated,
    output logic              rx_precache_overflow,
    input  logic [47:0]       r_sa_macaddr,
    input  logic              r_promisc_en,
    input  logic              r_hdr_strip,
    input  logic [LW-1:0]     r_rx_payload_byte_length,
    output logic [LW-1:0]     r_rx_payload_byte_real_length
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DROP, FLUSH} state_t;
    state_t state;

    logic [DW-1:0] mem_data [DEPTH];
    logic [NB-1:0] mem_be   [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic [DW-1:0] pack_data, pack_data_n;
    logic [NB-1:0] pack_be, pack_be_n;
    logic [3:0]    byte_idx, byte_idx_eff;
    logic [39:0]   da_sr;
    logic [47:0]   da_next;
    logic [LW-1:0] stored, stored_eff;
    logic          trunc, trunc_eff;
    logic          take, in_hdr, under_limit, store, over, da_match, mismatch;
    logic          push, pop, full, ovf, wr_en, kill;
    logic [LB-1:0] lane;

    // Per-frame counters read as zero in IDLE so the first byte starts a fresh frame.
    assign byte_idx_eff = (state == IDLE) ? '0 : byte_idx;
    assign stored_eff   = (state == IDLE) ? '0 : stored;
    assign trunc_eff    = (state == IDLE) ? 1'b0 : trunc;

    assign take        = rx_frame_byte_data_we &&
                         (state == IDLE || state == HDR || state == PAYLOAD);
    assign in_hdr      = byte_idx_eff < 4'd14;
    assign under_limit = ((r_rx_payload_byte_length == '0) ||
                          (stored_eff < r_rx_payload_byte_length)) && (stored_eff != '1);
    assign store       = take && !(r_hdr_strip && in_hdr) && under_limit;
    assign over        = take && !(r_hdr_strip && in_hdr) && !under_limit;
    assign lane        = stored_eff[LB-1:0];

    assign da_next  = {da_sr, rx_frame_byte_data};
    assign da_match = (da_next == r_sa_macaddr) || (da_next == 48'hFFFF_FFFF_FFFF) || r_promisc_en;
    assign mismatch = take && (state == HDR) && (byte_idx_eff == 4'd5) && !da_match;

    assign fill  = wr_ptr - rd_ptr;
    assign full  = (fill == FULL_LVL);
    assign push  = (state == HDR || state == PAYLOAD) ? (&pack_be) :
                   (state == FLUSH) ? (|pack_be) : 1'b0;
    assign pop   = (fill != '0) && rxdb_fifo_ready && (state == PAYLOAD || state == FLUSH);
    assign ovf   = push && full && !pop;
    assign wr_en = push && !ovf;
    assign kill  = ovf || mismatch || (state == DROP);

    always_comb begin
        pack_data_n = push ? '0 : pack_data;
        pack_be_n   = push ? '0 : pack_be;
        if (store) begin
            pack_data_n[8*lane +: 8] = rx_frame_byte_data;
            pack_be_n[lane]          = 1'b1;
        end
    end

    always_ff @(posedge pe_rx_clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= pack_data;
            mem_be[wr_ptr[AW-1:0]]   <= pack_be;
        end
    end

    always_ff @(posedge pe_rx_clk or negedge pe_rx_rstn) begin
        if (!pe_rx_rstn) begin
            state                         <= IDLE;
            wr_ptr                        <= '0;
            rd_ptr                        <= '0;
            pack_data                     <= '0;
            pack_be                       <= '0;
            byte_idx                      <= '0;
            da_sr                         <= '0;
            stored                        <= '0;
            trunc                         <= 1'b0;
            rxdb_pe2fifo_we               <= 1'b0;
            rxdb_pe2fifo_wdata            <= '0;
            rxdb_pe2fifo_wbe              <= '0;
            rxdb_pe2fifo_we_done          <= 1'b0;
            rx_handle_done                <= 1'b0;
            rx_frame_drop                 <= 1'b0;
            rx_frame_truncated            <= 1'b0;
            rx_precache_overflow          <= 1'b0;
        end else if (pe_rx_logic_clr) begin
            state                         <= IDLE;
            wr_ptr                        <= '0;
            rd_ptr                        <= '0;
            pack_data                     <= '0;
            pack_be                       <= '0;
            byte_idx                      <= '0;
            da_sr                         <= '0;
            stored                        <= '0;
            trunc                         <= 1'b0;
            rxdb_pe2fifo_we               <= 1'b0;
            rxdb_pe2fifo_wdata            <= '0;
            rxdb_pe2fifo_wbe              <= '0;
            rxdb_pe2fifo_we_done          <= 1'b0;
            rx_handle_done                <= 1'b0;
            rx_frame_drop                 <= 1'b0;
            rx_frame_truncated            <= 1'b0;
            rx_precache_overflow          <= 1'b0;
        end else begin
            rxdb_pe2fifo_we      <= pop;
            rxdb_pe2fifo_we_done <= 1'b0;
            rx_handle_done       <= 1'b0;
            rx_frame_drop        <= 1'b0;
            rx_frame_truncated   <= 1'b0;
            if (pop) begin
                rxdb_pe2fifo_wdata <= mem_data[rd_ptr[AW-1:0]];
                rxdb_pe2fifo_wbe   <= mem_be[rd_ptr[AW-1:0]];
                rd_ptr             <= rd_ptr + PTR_ONE;
            end
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (ovf) rx_precache_overflow <= 1'b1;
            pack_data <= pack_data_n;
            pack_be   <= pack_be_n;
            if (take) begin
                byte_idx <= in_hdr ? byte_idx_eff + 4'd1 : byte_idx_eff;
                stored   <= stored_eff + LW'(store);
                trunc    <= trunc_eff | over;
                if (byte_idx_eff < 4'd6) da_sr <= da_next[39:0];
            end
            // Rejected or overflowed frames lose everything already packed or cached.
            if (kill) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                pack_data <= '0;
                pack_be   <= '0;
            end

            unique case (state)
                IDLE: if (take) state <= HDR;
                HDR, PAYLOAD: begin
                    if (ovf || mismatch) begin
                        if (rx_frame_byte_data_done) begin
                            state              <= IDLE;
                            rx_handle_done     <= 1'b1;
                            rx_frame_drop      <= 1'b1;
                            rx_frame_truncated <= trunc_eff | over;
                        end else begin
                            state <= DROP;
                        end
                    end else if (rx_frame_byte_data_done) begin
                        state <= FLUSH;
                    end else if (state == HDR && take && byte_idx_eff == 4'd13) begin
                        state <= PAYLOAD;
                    end
                end
                DROP: if (rx_frame_byte_data_done) begin
                    state              <= IDLE;
                    rx_handle_done     <= 1'b1;
                    rx_frame_drop      <= 1'b1;
                    rx_frame_truncated <= trunc_eff;
                end
                FLUSH: begin
                    if (ovf) begin
                        state              <= IDLE;
                        rx_handle_done     <= 1'b1;
                        rx_frame_drop      <= 1'b1;
                        rx_frame_truncated <= trunc_eff;
                    end else if (fill == '0 && pack_be == '0) begin
                        state                <= IDLE;
                        rxdb_pe2fifo_we_done <= 1'b1;
                        rx_handle_done       <= 1'b1;
                        rx_frame_truncated   <= trunc_eff;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign r_rx_payload_byte_real_length = stored;

endmodule

// File: tb/tb_eth_mac_pe_rx_frame_packer.sv
// Directed bench: DW=32 and DW=64 packers driven by hand-built frames, checked against
// expected word contents, byte enables, lengths and status pulses.
module tb_eth_mac_pe_rx_frame_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, clr;
    logic [47:0] sa;
    logic        promisc, strip;
    logic [11:0] limit;

    logic [7:0]  a_byte, b_byte;
    logic        a_bwe, b_bwe, a_bdone, b_bdone, a_ready, b_ready;
    logic        a_we, b_we, a_wedone, b_wedone, a_hd, b_hd, a_drop, b_drop;
    logic        a_trunc, b_trunc, a_ovf, b_ovf;
    logic [31:0] a_wdata;
    logic [63:0] b_wdata;
    logic [3:0]  a_wbe;
    logic [7:0]  b_wbe;
    logic [11:0] a_real, b_real;

    eth_mac_pe_rx_frame_packer #(.DW(32), .DEPTH(4), .LW(12)) dut_a (
        .pe_rx_clk(clk), .pe_rx_rstn(rstn), .pe_rx_logic_clr(clr),
        .rx_frame_byte_data(a_byte), .rx_frame_byte_data_we(a_bwe),
        .rx_frame_byte_data_done(a_bdone), .rxdb_fifo_ready(a_ready),
        .rxdb_pe2fifo_we(a_we), .rxdb_pe2fifo_wdata(a_wdata), .rxdb_pe2fifo_wbe(a_wbe),
        .rxdb_pe2fifo_we_done(a_wedone), .rx_handle_done(a_hd), .rx_frame_drop(a_drop),
        .rx_frame_truncated(a_trunc), .rx_precache_overflow(a_ovf),
        .r_sa_macaddr(sa), .r_promisc_en(promisc), .r_hdr_strip(strip),
        .r_rx_payload_byte_length(limit), .r_rx_payload_byte_real_length(a_real));

    eth_mac_pe_rx_frame_packer #(.DW(64), .DEPTH(4), .LW(12)) dut_b (
        .pe_rx_clk(clk), .pe_rx_rstn(rstn), .pe_rx_logic_clr(clr),
        .rx_frame_byte_data(b_byte), .rx_frame_byte_data_we(b_bwe),
        .rx_frame_byte_data_done(b_bdone), .rxdb_fifo_ready(b_ready),
        .rxdb_pe2fifo_we(b_we), .rxdb_pe2fifo_wdata(b_wdata), .rxdb_pe2fifo_wbe(b_wbe),
        .rxdb_pe2fifo_we_done(b_wedone), .rx_handle_done(b_hd), .rx_frame_drop(b_drop),
        .rx_frame_truncated(b_trunc), .rx_precache_overflow(b_ovf),
        .r_sa_macaddr(sa), .r_promisc_en(promisc), .r_hdr_strip(strip),
        .r_rx_payload_byte_length(limit), .r_rx_payload_byte_real_length(b_real));

    int vectors = 0;
    int miscompares = 0;

    // Write/status monitor, sampled on the falling edge.
    logic [63:0] a_wd [512];
    logic [7:0]  a_wb [512];
    logic [63:0] b_wd [512];
    logic [7:0]  b_wb [512];
    int a_wr_n = 0, b_wr_n = 0, a_hd_n = 0, b_hd_n = 0, a_wdn_n = 0, b_wdn_n = 0;
    int a_both_n = 0, b_both_n = 0;
    logic a_last_drop = 1'b0, a_last_trunc = 1'b0, b_last_drop = 1'b0, b_last_trunc = 1'b0;

    always @(negedge clk) begin
        if (a_we) begin
            if (a_wr_n < 512) begin a_wd[a_wr_n] = {32'h0, a_wdata}; a_wb[a_wr_n] = {4'h0, a_wbe}; end
            a_wr_n++;
        end
        if (b_we) begin
            if (b_wr_n < 512) begin b_wd[b_wr_n] = b_wdata; b_wb[b_wr_n] = b_wbe; end
            b_wr_n++;
        end
        if (a_wedone) a_wdn_n++;
        if (b_wedone) b_wdn_n++;
        if (a_wedone && a_hd) a_both_n++;
        if (b_wedone && b_hd) b_both_n++;
        if (a_hd) begin a_hd_n++; a_last_drop = a_drop; a_last_trunc = a_trunc; end
        if (b_hd) begin b_hd_n++; b_last_drop = b_drop; b_last_trunc = b_trunc; end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [47:0] da, input int i);
        if (i < 6) return da[47-8*i -: 8];
        else if (i < 12) return 8'h10 + i[7:0];
        else if (i == 12) return 8'h08;
        else if (i == 13) return 8'h00;
        else return i[7:0];
    endfunction

    task automatic send_bytes(input bit sel, input logic [47:0] da, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            @(posedge clk); #1;
            if (sel) begin b_byte = fbyte(da, i); b_bwe = 1'b1; end
            else     begin a_byte = fbyte(da, i); a_bwe = 1'b1; end
        end
        @(posedge clk); #1;
        a_bwe = 1'b0; b_bwe = 1'b0;
    endtask

    task automatic send_done(input bit sel);
        if (sel) b_bdone = 1'b1; else a_bdone = 1'b1;
        @(posedge clk); #1;
        a_bdone = 1'b0; b_bdone = 1'b0;
    endtask

    task automatic wait_hd(input bit sel, input int prev);
        int n = 0;
        while (((sel ? b_hd_n : a_hd_n) == prev) && n < 400) begin
            @(posedge clk); n++;
        end
        check(sel ? "b_handle_done_seen" : "a_handle_done_seen", (sel ? b_hd_n : a_hd_n) - prev, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Checks the written words of one frame: payload bytes start at frame index base.
    task automatic check_words(input bit sel, input logic [47:0] da, input int base,
                               input int nstored, input int wr_base, input string tag);
        int nb = sel ? 8 : 4;
        int nw = (nstored + nb - 1) / nb;
        logic [63:0] ew;
        logic [7:0]  eb;
        check({tag, "_writes"}, (sel ? b_wr_n : a_wr_n) - wr_base, nw);
        for (int k = 0; k < nw; k++) begin
            ew = '0; eb = '0;
            for (int j = 0; j < nb; j++) begin
                if (k*nb + j < nstored) begin
                    ew[8*j +: 8] = fbyte(da, base + k*nb + j);
                    eb[j] = 1'b1;
                end
            end
            check({tag, "_wdata"}, sel ? b_wd[wr_base+k] : a_wd[wr_base+k], ew);
            check({tag, "_wbe"},   sel ? b_wb[wr_base+k] : a_wb[wr_base+k], eb);
        end
    endtask

    initial begin
        logic [47:0] da_own, da_bad, da_bc;
        int wb, hd0, wd0, both0;
        da_own = 48'h0A1B2C3D4E5F;
        da_bad = 48'h020000000099;
        da_bc  = 48'hFFFFFFFFFFFF;
        rstn = 1'b0; clr = 1'b0;
        sa = da_own; promisc = 1'b0; strip = 1'b0; limit = 12'd0;
        a_byte = 8'h0; b_byte = 8'h0; a_bwe = 1'b0; b_bwe = 1'b0;
        a_bdone = 1'b0; b_bdone = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_we", a_we, 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_wbe", a_wbe, 0);
        check("rst_we_done", a_wedone, 0);
        check("rst_handle_done", a_hd, 0);
        check("rst_drop", a_drop, 0);
        check("rst_trunc", a_trunc, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_real_len", a_real, 0);
        check("rst_b_wdata", b_wdata, 0);

        // Own DA, 64-byte frame, no strip
        wb = a_wr_n; hd0 = a_hd_n; wd0 = a_wdn_n; both0 = a_both_n;
        send_bytes(0, da_own, 0, 64);
        send_done(0);
        wait_hd(0, hd0);
        check_words(0, da_own, 0, 64, wb, "own64");
        check("own64_real_len", a_real, 64);
        check("own64_we_done", a_wdn_n - wd0, 1);
        check("own64_done_together", a_both_n - both0, 1);
        check("own64_drop", a_last_drop, 0);
        check("own64_trunc", a_last_trunc, 0);

        // Mismatching DA, promisc off
        wb = a_wr_n; hd0 = a_hd_n; wd0 = a_wdn_n;
        send_bytes(0, da_bad, 0, 64);
        send_done(0);
        wait_hd(0, hd0);
        check("bad_writes", a_wr_n - wb, 0);
        check("bad_drop", a_last_drop, 1);
        check("bad_we_done", a_wdn_n - wd0, 0);

        // Broadcast DA, header strip, 61-byte frame
        strip = 1'b1;
        wb = a_wr_n; hd0 = a_hd_n;
        send_bytes(0, da_bc, 0, 61);
        send_done(0);
        wait_hd(0, hd0);
        check_words(0, da_bc, 14, 47, wb, "bc61");
        check("bc61_last_wbe", a_wb[wb+11], 8'h07);
        check("bc61_real_len", a_real, 47);
        check("bc61_drop", a_last_drop, 0);

        // Length limit 20 on a 100-byte frame
        strip = 1'b0; limit = 12'd20;
        wb = a_wr_n; hd0 = a_hd_n;
        send_bytes(0, da_own, 0, 100);
        send_done(0);
        wait_hd(0, hd0);
        check_words(0, da_own, 0, 20, wb, "lim20");
        check("lim20_real_len", a_real, 20);
        check("lim20_trunc", a_last_trunc, 1);
        check("lim20_drop", a_last_drop, 0);
        limit = 12'd0;

        // Rxdb stalled: pre-cache overflow drops the frame; clear resets the flag
        a_ready = 1'b0;
        wb = a_wr_n; hd0 = a_hd_n; wd0 = a_wdn_n;
        send_bytes(0, da_own, 0, 32);
        send_done(0);
        wait_hd(0, hd0);
        check("ovf_flag", a_ovf, 1);
        check("ovf_drop", a_last_drop, 1);
        check("ovf_writes", a_wr_n - wb, 0);
        check("ovf_we_done", a_wdn_n - wd0, 0);
        a_ready = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_ovf_flag", a_ovf, 0);

        // DW=64: strip leaves 9 payload bytes
        strip = 1'b1;
        wb = b_wr_n; hd0 = b_hd_n;
        send_bytes(1, da_bc, 0, 23);
        send_done(1);
        wait_hd(1, hd0);
        check_words(1, da_bc, 14, 9, wb, "w64");
        check("w64_last_wbe", b_wb[wb+1], 8'h01);
        check("w64_real_len", b_real, 9);

        // DW=64: clear mid-frame, then a stray done must produce nothing
        wb = b_wr_n; hd0 = b_hd_n;
        send_bytes(1, da_bc, 0, 20);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        send_done(1);
        repeat (10) @(posedge clk);
        #1;
        check("clr_mid_writes", b_wr_n - wb, 0);
        check("clr_mid_handle_done", b_hd_n - hd0, 0);
        check("clr_mid_real_len", b_real, 0);
        check("clr_mid_we", b_we, 0);
        check("clr_mid_wbe", b_wbe, 0);
        check("clr_mid_wdata", b_wdata, 0);
        check("clr_mid_ovf", b_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
